// File: rtl/md_bus_merge_if.sv
// md_bus_merge_if -- bus-side signal bundle for one md_bus_merge instance.
//   drv_o / drv_d : NDRV*WIDTH driver values and per-bit high-Z disables
//                   (driver k at [k*WIDTH +: WIDTH], disable 1 = high-Z)
//   clr           : synchronous clear of sticky flags and contention counter
//   bus           : resolved bus value (registered)
//   floating      : per-bit "no driver last cycle"
//   contend       : one-cycle pulse, contention on any bit last cycle
//   contend_sticky: per-bit sticky contention flags
//   contend_cnt   : saturating count of contention cycles
// master = driver/observer side, slave = the merge block.
// WIDTH/NDRV/CNT_W must match the parameters of the attached md_bus_merge.
interface md_bus_merge_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDRV  = 4,
  parameter int unsigned CNT_W = 8
);
  logic [NDRV*WIDTH-1:0] drv_o;
  logic [NDRV*WIDTH-1:0] drv_d;
  logic                  clr;
  logic [WIDTH-1:0]      bus;
  logic [WIDTH-1:0]      floating;
  logic                  contend;
  logic [WIDTH-1:0]      contend_sticky;
  logic [CNT_W-1:0]      contend_cnt;

  modport master (
    output drv_o, drv_d, clr,
    input  bus, floating, contend, contend_sticky, contend_cnt
  );

  modport slave (
    input  drv_o, drv_d, clr,
    output bus, floating, contend, contend_sticky, contend_cnt
  );
endinterface

// File: rtl/md_bus_merge.sv
// md_bus_merge -- registered wired-OR resolver for a multi-driver board bus.
// Each bit ORs the values of its enabled drivers; undriven bits follow MODE
// (0 keeper, 1 pull-up, 2 pull-down). In keeper mode an optional decay loads
// DECAY_VAL after DECAY consecutive fully-undriven cycles. Contention (enabled
// drivers disagreeing on a bit) raises a pulse, per-bit sticky flags and a
// saturating cycle counter.
// Ports:
//   MCLK  : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bif   : md_bus_merge_if.slave (drivers, clr in; bus/flags/counter out)
// All outputs are registered; there is no input-to-output combinational path.

// Per-bit resolver: one instance per bus bit.
module md_bus_merge_bit #(
  parameter int unsigned NDRV = 4,
  parameter int unsigned MODE = 0
) (
  input  logic [NDRV-1:0] drv_o,
  input  logic [NDRV-1:0] drv_d,
  input  logic            cur,
  output logic            nxt,
  output logic            flt,
  output logic            con
);
  logic any_one, all_one;

  assign flt     = &drv_d;
  assign any_one = |(drv_o & ~drv_d);
  // disabled drivers count as '1' so only enabled zeros pull this low
  assign all_one = &(drv_o | drv_d);
  // at least one enabled 1 and at least one enabled 0
  assign con     = any_one & ~all_one;

  always_comb begin
    nxt = cur;
    if (!flt)           nxt = any_one;
    else if (MODE == 1) nxt = 1'b1;
    else if (MODE == 2) nxt = 1'b0;
  end
endmodule

module md_bus_merge #(
  parameter int unsigned     WIDTH     = 16,
  parameter int unsigned     NDRV      = 4,
  parameter int unsigned     MODE      = 0,
  parameter int unsigned     DECAY     = 0,
  parameter logic [WIDTH-1:0] DECAY_VAL = '0,
  parameter logic [WIDTH-1:0] RESET_VAL = '1,
  parameter int unsigned     CNT_W     = 8
) (
  input logic           MCLK,
  input logic           reset,
  md_bus_merge_if.slave bif
);
  // elaboration-time parameter checks
  if (MODE > 2) begin : g_mode_chk
    $error("md_bus_merge: illegal MODE %0d (0 keeper, 1 pull-up, 2 pull-down)", MODE);
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
    $error("md_bus_merge: WIDTH %0d out of range 1..32", WIDTH);
  end
  if (NDRV < 2 || NDRV > 8) begin : g_ndrv_chk
    $error("md_bus_merge: NDRV %0d out of range 2..8", NDRV);
  end

  localparam bit          DECAY_EN = (MODE == 0) && (DECAY > 0);
  localparam int unsigned DCW      = (DECAY > 0) ? $clog2(DECAY + 1) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] flt;
    logic             con;
    logic [WIDTH-1:0] stk;
    logic [CNT_W-1:0] cnt;
  } st_t;

  st_t              st_q, st_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;

  // driver-major input transposed to bit-major for the per-bit resolvers
  logic [WIDTH-1:0][NDRV-1:0] bit_o, bit_d;
  logic [WIDTH-1:0]           res, flt_v, con_v, bus_cur;
  logic                       all_flt, any_con, decay_hit;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar k = 0; k < NDRV; k++) begin : g_drv
      assign bit_o[b][k] = bif.drv_o[k*WIDTH + b];
      assign bit_d[b][k] = bif.drv_d[k*WIDTH + b];
    end
  end

  assign bus_cur = st_q.bus;

  md_bus_merge_bit #(.NDRV(NDRV), .MODE(MODE)) u_bit [WIDTH-1:0] (
    .drv_o (bit_o),
    .drv_d (bit_d),
    .cur   (bus_cur),
    .nxt   (res),
    .flt   (flt_v),
    .con   (con_v)
  );

  assign all_flt = &flt_v;
  assign any_con = |con_v;

  // Decay counter: counts fully-undriven cycles, saturating at DECAY. The
  // bus loads DECAY_VAL on the edge the count reaches DECAY and keeps doing
  // so while it sits there; any driven bit restarts the count.
  always_comb begin
    dcnt_d    = '0;
    decay_hit = 1'b0;
    if (DECAY_EN && all_flt) begin
      dcnt_d    = (dcnt_q == DCW'(DECAY)) ? dcnt_q : dcnt_q + 1'b1;
      decay_hit = (dcnt_d == DCW'(DECAY));
    end
  end

  always_comb begin
    st_d     = st_q;
    st_d.bus = decay_hit ? DECAY_VAL : res;
    st_d.flt = flt_v;
    st_d.con = any_con;
    // clr wipes history but this cycle's contention still lands
    st_d.stk = (bif.clr ? '0 : st_q.stk) | con_v;
    if (bif.clr)
      st_d.cnt = CNT_W'(any_con);
    else if (any_con && (st_q.cnt != {CNT_W{1'b1}}))
      st_d.cnt = st_q.cnt + 1'b1;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      st_q.bus <= RESET_VAL;
      st_q.flt <= '1;
      st_q.con <= 1'b0;
      st_q.stk <= '0;
      st_q.cnt <= '0;
      dcnt_q   <= '0;
    end else begin
      st_q   <= st_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign bif.bus            = st_q.bus;
  assign bif.floating       = st_q.flt;
  assign bif.contend        = st_q.con;
  assign bif.contend_sticky = st_q.stk;
  assign bif.contend_cnt    = st_q.cnt;
endmodule

// File: doc/md_bus_merge.md
# md_bus_merge

Parametrised, registered resolver for a multi-driver board bus such as VD, VA, ZD or ZA. It merges N tri-state drivers into one bus value per clock using the same wired-OR rule the board already applies. It adds three things the board does not have: a selectable undriven-bus policy (keeper, pull-up or pull-down), open-bus decay, and contention detection with sticky flags and a saturating event counter. It is instantiated once per shared bus in the board top-level, and its outputs feed the chipset, CPU and memory inputs.

## Interface
Parameters:
- WIDTH, 16, bus width in bits (1..32).
- NDRV, 4, number of drivers (2..8).
- MODE, 0, policy for undriven bits: 0 keeper (hold last value), 1 pull-up, 2 pull-down.
- DECAY, 0, MODE 0 only. Number of consecutive fully-undriven cycles after which the bus decays to DECAY_VAL. 0 disables decay.
- DECAY_VAL, 0, value the bus takes on decay (WIDTH bits).
- RESET_VAL, all ones, bus value while reset is asserted.
- CNT_W, 8, width of the contention counter.

Ports:
- MCLK  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- drv_o  in  NDRV*WIDTH  driver values; driver k occupies bits [k*WIDTH +: WIDTH].
- drv_d  in  NDRV*WIDTH  per-bit disable; 1 = that driver bit is high-Z, 0 = it drives.
- clr  in  1  synchronous clear of the sticky flags and the counter.
- bus  out  WIDTH  resolved bus value (registered).
- floating  out  WIDTH  registered; 1 = that bit had no driver last cycle.
- contend  out  1  registered one-cycle pulse; contention on any bit last cycle.
- contend_sticky  out  WIDTH  per-bit sticky contention flags.
- contend_cnt  out  CNT_W  saturating count of cycles with contention.

## Operation
- For each bit b, the driven set is every driver k with drv_d[k*WIDTH+b] = 0.
- Driven bit (set non-empty): the next value is the OR of drv_o over the driven set (wired-OR).
- Contention on bit b: two or more drivers in the driven set, with differing values. Equal values from several drivers are not contention.
- Undriven bit, MODE 1: next value is 1.
- Undriven bit, MODE 2: next value is 0.
- Undriven bit, MODE 0: next value is the current bus bit (keeper).
- Decay counter (MODE 0, DECAY > 0):
  - Increments, saturating at DECAY, on every cycle in which all WIDTH bits are undriven.
  - Clears on any cycle in which at least one bit is driven.
  - On the cycle the counter reaches DECAY, bus loads DECAY_VAL and keeps loading it while the bus stays fully undriven.
  - Partially driven buses never decay: driven bits resolve as above and undriven bits keep.
- floating[b] is set when bit b was undriven, regardless of MODE.
- contend = OR over bits of contention.
- contend_sticky[b] is set on contention of bit b and holds until clr or reset.
- contend_cnt increments by 1 per contention cycle and saturates at 2^CNT_W-1.
- clr and contention in the same cycle: the cycle's event still registers, so after that edge contend_sticky shows only the current bits and contend_cnt = 1.
- MODE values other than 0..2 are illegal and must be caught by an elaboration-time check.

## Timing
- Latency is one MCLK cycle: inputs sampled at edge n appear on bus, floating and contend after edge n. This matches the board's registered bus merge.
- Reset (asynchronous assert, released synchronously by the surrounding design):
  - bus = RESET_VAL, floating = all ones.
  - contend = 0, contend_sticky = 0, contend_cnt = 0.
  - decay counter = 0.
- Reset mid-decay restarts the count from 0. The keeper then holds RESET_VAL.
- There is no combinational path from inputs to outputs.

## Test plan
- Single-driver pass-through (WIDTH=16, NDRV=4, MODE 0): driver 2 drives 0xA5C3 with all others high-Z -> bus = 0xA5C3 one cycle later, floating = 0, contend = 0.
- Keeper and decay (MODE 0, DECAY=3, DECAY_VAL=0): drive 0x1234 for one cycle, then all drivers high-Z -> bus holds 0x1234 for 2 cycles and reads 0x0000 from the 3rd undriven cycle. A driver re-driving 0x00FF clears the count and bus = 0x00FF.
- Pull modes: all drivers high-Z -> bus = 0xFFFF in MODE 1 and 0x0000 in MODE 2. Bits 7:0 driven to 0x00 with bits 15:8 floating (MODE 1) -> bus = 0xFF00, floating = 0xFF00.
- Contention: driver 0 drives 0x0001 and driver 1 drives 0x0000, both enabled on bit 0 -> bus = 0x0001, contend pulses for 1 cycle, contend_sticky = 0x0001, contend_cnt = 1. Two drivers both driving 0x0001 -> no contention.
- Counter saturation and clear (CNT_W=2): 5 contention cycles -> contend_cnt = 3. Assert clr during a further contention cycle -> contend_cnt = 1 and contend_sticky holds only the current bits. Assert clr alone -> both read 0.
- Asynchronous reset mid-operation: assert reset between clock edges while bus = 0x1234 -> bus = RESET_VAL immediately and all flags and counters = 0. After release with no drivers, MODE 0 holds RESET_VAL.
